// File: rtl/led_pkg.sv
// Shared control-region LED types: lamp-test FSM states and default timing constants
// for the 40 MHz fabric clock.
package led_pkg;

    typedef enum logic [1:0] {
        StRst,
        StAll,
        StWalk,
        StRun
    } lamp_state_t;

    localparam int unsigned LED_STRETCH_CYCLES   = 2000000;
    localparam int unsigned LED_LAMP_ALL_CYCLES  = 40000000;
    localparam int unsigned LED_LAMP_STEP_CYCLES = 4000000;

endpackage

// File: rtl/led_pulse_stretch.sv
// One-bit pulse stretcher: holds its output high for at least STRETCH_CYCLES clocks
// after each rising edge of the input.
module led_pulse_stretch
    import led_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = LED_STRETCH_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic led_i,
    output logic led_o
);

    localparam int unsigned CntWidth = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(STRETCH_CYCLES);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                led_prev_q;

    // A rising edge inside an active window reloads rather than accumulates.
    always_comb begin
        cnt_d = cnt_q;
        if (led_i && !led_prev_q) begin
            cnt_d = CntLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            led_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            led_prev_q <= led_i;
        end
    end

    assign led_o = led_i | (cnt_q != '0);

endmodule

// File: rtl/led_output_driver.sv
// Front-panel LED output stage: per-LED stretching, global PWM dimming, lamp-test
// sequencing and board polarity on a registered pin drive.
module led_output_driver
    import led_pkg::*;
#(
    parameter int unsigned MXLEDS           = 16,
    parameter int unsigned STRETCH_CYCLES   = LED_STRETCH_CYCLES,
    parameter int unsigned PWM_BITS         = 4,
    parameter int unsigned LAMP_ALL_CYCLES  = LED_LAMP_ALL_CYCLES,
    parameter int unsigned LAMP_STEP_CYCLES = LED_LAMP_STEP_CYCLES,
    parameter bit          INVERT           = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [MXLEDS-1:0]   led_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    input  logic                lamp_test_i,
    output logic [MXLEDS-1:0]   led_o,
    output logic                lamp_busy_o
);

    localparam int unsigned TimerWidth = $clog2(LAMP_ALL_CYCLES + LAMP_STEP_CYCLES);
    localparam int unsigned IdxWidth   = $clog2(MXLEDS);

    localparam logic [TimerWidth-1:0] AllLast  = TimerWidth'(LAMP_ALL_CYCLES - 1);
    localparam logic [TimerWidth-1:0] StepLast = TimerWidth'(LAMP_STEP_CYCLES - 1);
    localparam logic [IdxWidth-1:0]   IdxLast  = IdxWidth'(MXLEDS - 1);
    localparam logic [MXLEDS-1:0]     PolMask  = {MXLEDS{INVERT}};

    logic [MXLEDS-1:0]     led_q;
    logic [MXLEDS-1:0]     stretched;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic [PWM_BITS-1:0]   bright_q;
    logic                  pwm_on;
    lamp_state_t           state_q;
    logic [TimerWidth-1:0] timer_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [MXLEDS-1:0]     sel;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_i;
        end
    end

    for (genvar g = 0; g < MXLEDS; g++) begin : g_stretch
        led_pulse_stretch #(
            .STRETCH_CYCLES (STRETCH_CYCLES)
        ) u_stretch (
            .clock   (clock),
            .reset_n (reset_n),
            .led_i   (led_q[g]),
            .led_o   (stretched[g])
        );
    end

    // Brightness is only picked up at the period boundary so duty never glitches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (pwm_cnt_q == '1) begin
                bright_q <= brightness_i;
            end
        end
    end

    assign pwm_on = (pwm_cnt_q <= bright_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StRst;
            timer_q     <= '0;
            idx_q       <= '0;
            lamp_busy_o <= 1'b1;
        end else begin
            case (state_q)
                StRst: begin
                    state_q     <= StAll;
                    timer_q     <= '0;
                    lamp_busy_o <= 1'b1;
                end
                StAll: begin
                    if (timer_q == AllLast) begin
                        state_q <= StWalk;
                        timer_q <= '0;
                        idx_q   <= '0;
                    end else begin
                        timer_q <= timer_q + TimerWidth'(1);
                    end
                end
                StWalk: begin
                    if (timer_q == StepLast) begin
                        timer_q <= '0;
                        if (idx_q == IdxLast) begin
                            state_q     <= StRun;
                            lamp_busy_o <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IdxWidth'(1);
                        end
                    end else begin
                        timer_q <= timer_q + TimerWidth'(1);
                    end
                end
                StRun: begin
                    if (lamp_test_i) begin
                        state_q     <= StAll;
                        timer_q     <= '0;
                        lamp_busy_o <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StRst;
                    lamp_busy_o <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        sel = '0;
        case (state_q)
            StAll:   sel = '1;
            StWalk:  sel[idx_q] = 1'b1;
            StRun:   sel = stretched & {MXLEDS{pwm_on}};
            default: sel = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            led_o <= PolMask;
        end else begin
            led_o <= sel ^ PolMask;
        end
    end

endmodule

// File: tb/tb_led_output_driver.sv
// Directed bench for led_output_driver; normal and inverted-polarity instances share
// stimulus and are checked against a scoreboard of expected pin states.
module tb_led_output_driver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] led_i;
    logic [3:0]  brightness_i;
    logic        lamp_test_i;
    logic [15:0] led0, led1;
    logic        busy0, busy1;

    always #5 clock = ~clock;

    led_output_driver #(
        .MXLEDS           (16),
        .STRETCH_CYCLES   (10),
        .PWM_BITS         (4),
        .LAMP_ALL_CYCLES  (8),
        .LAMP_STEP_CYCLES (2),
        .INVERT           (1'b0)
    ) u_dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .led_i        (led_i),
        .brightness_i (brightness_i),
        .lamp_test_i  (lamp_test_i),
        .led_o        (led0),
        .lamp_busy_o  (busy0)
    );

    led_output_driver #(
        .MXLEDS           (16),
        .STRETCH_CYCLES   (10),
        .PWM_BITS         (4),
        .LAMP_ALL_CYCLES  (8),
        .LAMP_STEP_CYCLES (2),
        .INVERT           (1'b1)
    ) u_dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .led_i        (led_i),
        .brightness_i (brightness_i),
        .lamp_test_i  (lamp_test_i),
        .led_o        (led1),
        .lamp_busy_o  (busy1)
    );

    typedef struct {
        logic [15:0] mask;
        logic        busy;
        bit          use_pwm;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          on_cnt = 0;
    int          busy_cnt = 0;
    logic [3:0]  m_pwm = '0;
    logic [3:0]  m_bright = '0;

    task automatic push(logic [15:0] mask, logic busy, bit use_pwm, string tag, int n);
        exp_t e;
        e.mask    = mask;
        e.busy    = busy;
        e.use_pwm = use_pwm;
        e.tag     = tag;
        repeat (n) sb.push_back(e);
    endtask

    // Entry j is the pin state j+1 cycles after the FSM leaves RST or RUN.
    task automatic push_lamp(int upto, string tag);
        logic [15:0] m;
        for (int j = 0; j < upto; j++) begin
            if (j == 0) m = 16'h0000;
            else if (j <= 8) m = 16'hFFFF;
            else m = 16'h0001 << ((j - 9) / 2);
            push(m, (j < 40), 1'b0, tag, 1);
        end
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            logic        on;
            exp_t        e;
            logic [15:0] exp_led;
            on = (m_pwm <= m_bright);
            @(posedge clock);
            if (!reset_n) begin
                m_pwm    = '0;
                m_bright = '0;
            end else begin
                if (m_pwm == 4'hF) m_bright = brightness_i;
                m_pwm = m_pwm + 4'd1;
            end
            #1;
            if (led0[0]) on_cnt++;
            if (busy0) busy_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow got empty queue required an entry");
            end else begin
                e = sb.pop_front();
                exp_led = e.use_pwm ? (on ? e.mask : 16'h0000) : e.mask;
                checks++;
                assert ({led0, busy0} === {exp_led, e.busy}) else begin
                    errors++;
                    $error("FAIL %s dut0 led_o/busy got %h/%b required %h/%b",
                           e.tag, led0, busy0, exp_led, e.busy);
                end
                checks++;
                assert ({led1, busy1} === {exp_led ^ 16'hFFFF, e.busy}) else begin
                    errors++;
                    $error("FAIL %s dut1 led_o/busy got %h/%b required %h/%b",
                           e.tag, led1, busy1, exp_led ^ 16'hFFFF, e.busy);
                end
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        led_i        = '0;
        brightness_i = 4'hF;
        lamp_test_i  = 1'b0;

        push(16'h0000, 1'b1, 1'b0, "reset", 3);
        step(3);

        reset_n  = 1'b1;
        busy_cnt = 0;
        push_lamp(41, "release_lamp");
        step(41);
        checks++;
        assert (busy_cnt === 40) else begin
            errors++;
            $error("FAIL release_busy_time got %0d required %0d", busy_cnt, 40);
        end
        push(16'h0000, 1'b0, 1'b0, "run_idle", 3);
        step(3);

        // Single one-cycle pulse on LED 11.
        led_i = 16'h0800;
        push(16'h0000, 1'b0, 1'b0, "pulse_lat", 1);
        push(16'h0800, 1'b0, 1'b0, "pulse_on", 11);
        push(16'h0000, 1'b0, 1'b0, "pulse_off", 3);
        step(1);
        led_i = '0;
        step(14);

        // Retrigger five cycles later extends the window.
        led_i = 16'h0800;
        push(16'h0000, 1'b0, 1'b0, "retrig_lat", 1);
        push(16'h0800, 1'b0, 1'b0, "retrig_on", 16);
        push(16'h0000, 1'b0, 1'b0, "retrig_off", 2);
        step(1);
        led_i = '0;
        step(4);
        led_i = 16'h0800;
        step(1);
        led_i = '0;
        step(13);

        // PWM dimming with all LEDs held on.
        led_i        = 16'hFFFF;
        brightness_i = 4'd3;
        push(16'h0000, 1'b0, 1'b1, "pwm3_lat", 1);
        push(16'hFFFF, 1'b0, 1'b1, "pwm3", 35);
        step(20);
        on_cnt = 0;
        step(16);
        checks++;
        assert (on_cnt === 4) else begin
            errors++;
            $error("FAIL pwm3_duty got %0d required %0d", on_cnt, 4);
        end
        for (int i = 0; i < 16 && m_pwm != 4'd1; i++) begin
            push(16'hFFFF, 1'b0, 1'b1, "pwm_align", 1);
            step(1);
        end
        brightness_i = 4'd7;
        push(16'hFFFF, 1'b0, 1'b1, "pwm7", 40);
        step(24);
        on_cnt = 0;
        step(16);
        checks++;
        assert (on_cnt === 8) else begin
            errors++;
            $error("FAIL pwm7_duty got %0d required %0d", on_cnt, 8);
        end

        led_i        = '0;
        brightness_i = 4'hF;
        push(16'hFFFF, 1'b0, 1'b1, "pwm_release", 1);
        push(16'h0000, 1'b0, 1'b1, "pwm_dark", 20);
        step(21);

        // Lamp-test request in RUN, second request during WALK is ignored.
        lamp_test_i = 1'b1;
        busy_cnt    = 0;
        push_lamp(41, "lamp_req");
        step(1);
        lamp_test_i = 1'b0;
        step(14);
        lamp_test_i = 1'b1;
        step(1);
        lamp_test_i = 1'b0;
        step(25);
        checks++;
        assert (busy_cnt === 40) else begin
            errors++;
            $error("FAIL lamp_req_busy_time got %0d required %0d", busy_cnt, 40);
        end
        push(16'h0000, 1'b0, 1'b0, "lamp_req_done", 3);
        step(3);

        // Reset in the middle of WALK aborts and restarts the sequence.
        lamp_test_i = 1'b1;
        push_lamp(20, "walk_pre_reset");
        step(1);
        lamp_test_i = 1'b0;
        step(19);
        reset_n = 1'b0;
        push(16'h0000, 1'b1, 1'b0, "mid_walk_reset", 3);
        step(3);
        reset_n = 1'b1;
        push_lamp(41, "restart_lamp");
        step(41);
        push(16'h0000, 1'b0, 1'b0, "restart_done", 3);
        step(3);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got %0d required %0d", sb.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
